// File: rtl/fetch_queue.sv
// fetch_queue -- instruction-byte fetch unit for the 6502 frontend.
//
// After reset the unit reads the 16-bit reset vector (low byte at RESET_VEC,
// high byte at RESET_VEC+1). It then streams sequential bytes from memory
// into a circular byte queue. Up to DEQ_W head bytes are presented to the
// decoder each cycle, together with the PC of the head byte. A redirect
// flushes the queue and restarts fetching at a new PC. The memory port is
// shared through a request/grant handshake. Read data returns exactly one
// cycle after an accepted request.
//
// Ports:
//   clk            clock
//   rst            asynchronous reset, active-low
//   mem_req        fetch request
//   mem_addr       fetch address (meaningful while mem_req=1)
//   mem_gnt        request accepted this cycle
//   mem_rdata      read data, valid one cycle after an accepted request
//   redirect_valid flush the queue and restart fetch at redirect_pc
//   redirect_pc    new fetch PC
//   out_valid      bit i set when the queue holds more than i bytes
//   out_data       byte i at [8i+7:8i]; the head byte is byte 0
//   out_pc         PC of the head byte
//   out_take       bytes consumed this cycle (saturated at the occupancy)
//   count          current occupancy
//
// Optional build macro FETCH_QUEUE_PERF_EN adds two saturating counters:
//   stall_cycles   RUN cycles with an empty queue and no redirect
//   flush_count    number of redirect cycles

module fetch_queue #(
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 8,
  parameter int                DEQ_W     = 2,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(16'hFFFC)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_gnt,
  input  logic [7:0]                   mem_rdata,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic [DEQ_W-1:0]             out_valid,
  output logic [8*DEQ_W-1:0]           out_data,
  output logic [ADDR_W-1:0]            out_pc,
  input  logic [$clog2(DEQ_W+1)-1:0]   out_take,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [15:0]                  flush_count
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int TAKE_W = $clog2(DEQ_W+1);

  typedef enum logic [1:0] {
    S_VEC_LO = 2'd0,
    S_VEC_HI = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  // A take larger than the occupancy is clamped to the occupancy.
  function automatic logic [TAKE_W-1:0] sat_take(input logic [TAKE_W-1:0] take,
                                                 input logic [CNT_W-1:0]  cnt);
    if (CNT_W'(take) > cnt) return TAKE_W'(cnt);
    return take;
  endfunction

  // Control state
  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rsp_pending;
  logic [CNT_W-1:0]    r_count;
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [ADDR_W-1:0]   r_out_pc;

  // Data storage (not reset)
  logic [7:0]          r_mem [DEPTH];
  logic [7:0]          r_vec_lo;

  logic                w_mem_req;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic                w_has_room;
  logic                w_grant;
  logic                w_push;
  logic [TAKE_W-1:0]   w_take;
  logic                w_vec_hi_done;

  // The capacity check counts the byte still in flight so a granted response
  // always finds a free slot, even if the decoder takes nothing.
  assign w_has_room = ({1'b0, r_count} + (CNT_W+1)'(r_rsp_pending)) < (CNT_W+1)'(DEPTH);

  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = 1'b0;
    w_mem_addr  = r_fetch_pc;
    case (r_state)
      S_VEC_LO: begin
        w_mem_addr = RESET_VEC;
        w_mem_req  = !r_rsp_pending;
        if (r_rsp_pending) w_state_nxt = S_VEC_HI;
      end
      S_VEC_HI: begin
        w_mem_addr = RESET_VEC + ADDR_W'(1);
        w_mem_req  = !r_rsp_pending;
        if (r_rsp_pending) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_mem_req = w_has_room;
      end
      default: begin
        w_state_nxt = S_VEC_LO;
      end
    endcase
    if (redirect_valid) begin
      w_state_nxt = S_RUN;
      w_mem_req   = 1'b0;
    end
  end

  // Gating with rst keeps the request low while reset is held.
  assign mem_req  = w_mem_req & rst;
  assign mem_addr = w_mem_addr;

  assign w_grant       = mem_req & mem_gnt;
  // A response landing in a redirect cycle belongs to the old stream.
  assign w_push        = r_rsp_pending && (r_state == S_RUN) && !redirect_valid;
  assign w_vec_hi_done = r_rsp_pending && (r_state == S_VEC_HI) && !redirect_valid;
  assign w_take        = redirect_valid ? '0 : sat_take(out_take, r_count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_VEC_LO;
      r_rsp_pending <= 1'b0;
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_fetch_pc    <= '0;
      r_out_pc      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rsp_pending <= w_grant;
      if (redirect_valid) begin
        r_count    <= '0;
        r_head     <= r_tail;
        r_fetch_pc <= redirect_pc;
        r_out_pc   <= redirect_pc;
      end else begin
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_take);
        r_head  <= r_head + PTR_W'(w_take);
        r_tail  <= r_tail + PTR_W'(w_push);
        if (w_vec_hi_done) begin
          r_fetch_pc <= ADDR_W'({mem_rdata, r_vec_lo});
          r_out_pc   <= ADDR_W'({mem_rdata, r_vec_lo});
        end else begin
          if (w_grant && (r_state == S_RUN)) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
          r_out_pc <= r_out_pc + ADDR_W'(w_take);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= mem_rdata;
    if (r_rsp_pending && (r_state == S_VEC_LO)) r_vec_lo <= mem_rdata;
  end

  // Head window: bytes past the occupancy are don't-care.
  for (genvar gi = 0; gi < DEQ_W; gi++) begin : g_head
    logic [PTR_W-1:0] w_idx;
    assign w_idx                = r_head + PTR_W'(gi);
    assign out_data[8*gi +: 8]  = r_mem[w_idx];
    assign out_valid[gi]        = r_count > CNT_W'(gi);
  end

  assign out_pc = r_out_pc;
  assign count  = r_count;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(w_push && (r_count == CNT_W'(DEPTH)) && (w_take == '0)))
        else $error("fetch_queue: enqueue into a full queue");
      if (!redirect_valid)
        assert (CNT_W'(out_take) <= r_count)
          else $error("fetch_queue: out_take %0d exceeds count %0d", out_take, r_count);
    end
  end
`endif

`ifdef FETCH_QUEUE_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if ((r_state == S_RUN) && (r_count == '0) && !redirect_valid)
        r_stall_cycles <= sat_inc32(r_stall_cycles);
      if (redirect_valid)
        r_flush_count <= sat_inc16(r_flush_count);
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (ADDR_W=16, DEPTH=8, DEQ_W=2).
// Memory model: FFFC=34, FFFD=12, every other address returns its low byte;
// idle cycles return EE so a spurious enqueue shows up as a wrong byte.

module tb_fetch_queue;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 8;
  localparam int DEQ_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req;
  logic [15:0]       mem_addr;
  logic              mem_gnt;
  logic [7:0]        mem_rdata;
  logic              redirect_valid;
  logic [15:0]       redirect_pc;
  logic [1:0]        out_valid;
  logic [15:0]       out_data;
  logic [15:0]       out_pc;
  logic [1:0]        out_take;
  logic [3:0]        count;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0]       stall_cycles;
  logic [15:0]       flush_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] grant_q[$];

  fetch_queue #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DEQ_W(DEQ_W), .RESET_VEC(16'hFFFC)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_data(out_data), .out_pc(out_pc),
    .out_take(out_take), .count(count)
`ifdef FETCH_QUEUE_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [15:0] a);
    if (a == 16'hFFFC) return 8'h34;
    if (a == 16'hFFFD) return 8'h12;
    return a[7:0];
  endfunction

  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      grant_q.push_back(mem_addr);
      mem_rdata <= memf(mem_addr);
    end else begin
      mem_rdata <= 8'hEE;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic int popcnt(input logic [1:0] v);
    int n = 0;
    for (int b = 0; b < DEQ_W; b++) if (v[b]) n++;
    return n;
  endfunction

  initial begin
    int g0;
    int got;
    int n;
    int recv;
    int serr;
    logic [31:0] collected;
    logic [15:0] exp_addr;

    rst            = 1'b0;
    mem_gnt        = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    out_take       = 2'd0;

    // Reset state
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);

    // Reset vector fetch
    rst = 1'b1;
    for (int i = 0; i < 30 && !out_valid[0]; i++) tick();
    chk("vec_first_valid", 32'(out_valid[0]), 32'd1);
    chk("vec_out_pc", 32'(out_pc), 32'h1234);
    chk("vec_head_byte", 32'(out_data[7:0]), 32'h34);
    chk("vec_req0", 32'(grant_q[0]), 32'hFFFC);
    chk("vec_req1", 32'(grant_q[1]), 32'hFFFD);
    chk("vec_req2", 32'(grant_q[2]), 32'h1234);

    // Fill to full with no dequeue
    for (int i = 0; i < 40 && (mem_req || count != 4'd8); i++) tick();
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_req_low", 32'(mem_req), 32'd0);
    chk("fill_grants", 32'(grant_q.size()), 32'd10);
    chk("fill_head2", 32'(out_data), 32'h3534);
    chk("fill_pc", 32'(out_pc), 32'h1234);

    // Take two, then hold the grant low for five cycles
    out_take = 2'd2;
    tick();
    out_take = 2'd0;
    mem_gnt  = 1'b0;
    #1;
    chk("take_count", 32'(count), 32'd6);
    chk("take_pc", 32'(out_pc), 32'h1236);
    chk("take_head2", 32'(out_data), 32'h3736);
    chk("resume_req", 32'({mem_req, mem_addr}), 32'h1123C);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_req_addr", 32'({mem_req, mem_addr}), 32'h1123C);
      chk("bp_count", 32'(count), 32'd6);
    end
    mem_gnt = 1'b1;
    tick(); tick();
    chk("bp_resume_count", 32'(count), 32'd7);
    chk("bp_resume_req", 32'(mem_req), 32'd0);
    tick();
    chk("bp_full_count", 32'(count), 32'd8);
    chk("bp_grants", 32'(grant_q.size()), 32'd12);
    chk("bp_last_grant", 32'(grant_q[11]), 32'h123D);

    // Redirect while a response is in flight; out_take is ignored
    out_take = 2'd2;
    tick();
    out_take = 2'd0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h8000;
    out_take       = 2'd2;
    #1;
    chk("redir_req_forced", 32'(mem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    out_take       = 2'd0;
    #1;
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_pc", 32'(out_pc), 32'h8000);
    chk("redir_req_addr", 32'({mem_req, mem_addr}), 32'h18000);
    for (int i = 0; i < 10 && !out_valid[0]; i++) tick();
    chk("redir_head_valid", 32'(out_valid[0]), 32'd1);
    chk("redir_head_byte", 32'(out_data[7:0]), 32'h00);
    chk("redir_head_pc", 32'(out_pc), 32'h8000);
    chk("redir_killed_grant", 32'(grant_q[12]), 32'h123E);
    chk("redir_new_grant", 32'(grant_q[13]), 32'h8000);

    // PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    g0        = grant_q.size();
    got       = 0;
    collected = 32'd0;
    for (int i = 0; i < 40 && got < 4; i++) begin
      #1;
      n = popcnt(out_valid);
      if (n > 4 - got) n = 4 - got;
      for (int k = 0; k < n; k++) begin
        collected = collected | (32'(out_data[8*k +: 8]) << (8*got));
        got++;
      end
      out_take = 2'(n);
      tick();
    end
    out_take = 2'd0;
    #1;
    chk("wrap_got", 32'(got), 32'd4);
    chk("wrap_bytes", collected, 32'h0100FFFE);
    chk("wrap_out_pc", 32'(out_pc), 32'h0002);
    chk("wrap_addr0", 32'(grant_q[g0]), 32'hFFFE);
    chk("wrap_addr1", 32'(grant_q[g0+1]), 32'hFFFF);
    chk("wrap_addr2", 32'(grant_q[g0+2]), 32'h0000);
    chk("wrap_addr3", 32'(grant_q[g0+3]), 32'h0001);

    // Streaming 100 bytes with full consumption every cycle
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    exp_addr = 16'h0100;
    recv     = 0;
    serr     = 0;
    for (int i = 0; i < 600 && recv < 100; i++) begin
      #1;
      n = popcnt(out_valid);
      for (int k = 0; k < n; k++) begin
        if (out_data[8*k +: 8] !== exp_addr[7:0]) serr++;
        exp_addr = exp_addr + 16'd1;
        recv++;
      end
      out_take = 2'(n);
      tick();
    end
    out_take = 2'd0;
    #1;
    chk("stream_recv", 32'(recv >= 100), 32'd1);
    chk("stream_order_errs", 32'(serr), 32'd0);
    chk("stream_out_pc", 32'(out_pc), 32'(exp_addr));

    // Reset mid-operation
    rst = 1'b0;
    #1;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_req", 32'(mem_req), 32'd0);
    chk("mrst_pc", 32'(out_pc), 32'd0);
    tick();
    rst = 1'b1;
    g0  = grant_q.size();
    for (int i = 0; i < 30 && !out_valid[0]; i++) tick();
    chk("mrst_vec_req", 32'(grant_q[g0]), 32'hFFFC);
    chk("mrst_out_pc", 32'(out_pc), 32'h1234);
    chk("mrst_head_byte", 32'(out_data[7:0]), 32'h34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
